// File: rtl/uart_tx_serializer_pkg.sv
//==============================================================================
// Module      : uart_tx_serializer_pkg
// Description : Shared baud constants, FSM state encoding and sizing helper
//               for the 8N1 UART transmit serializer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_tx_serializer_pkg;

    // Clocks per bit for a 50 MHz system clock
    localparam int CLKS_PER_BIT_9600   = 5208;
    localparam int CLKS_PER_BIT_115200 = 434;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_READ  = 3'd1,
        TX_LATCH = 3'd2,
        TX_START = 3'd3,
        TX_DATA  = 3'd4,
        TX_STOP  = 3'd5
    } tx_state_t;

    // Width of a counter that spans 0..clks_per_bit-1; never narrower than 1
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit < 3) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer_baud_tick.sv
//==============================================================================
// Module      : uart_baud_tick
// Description : Wrap counter 0..CLKS_PER_BIT-1; tick marks the last cycle of
//               each bit period. clear restarts the period from zero.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_baud_tick
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int               c_cnt_w = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
//==============================================================================
// Module      : uart_tx_serializer
// Description : Pops bytes from a standard-read FIFO and sends each one as an
//               8N1 frame on txData. All outputs are registered.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600   // legal 2..65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       empty,
    input  logic [7:0] dout,
    output logic       readEn,
    output logic       txData,
    output logic       busy,
    output logic       txDone
);

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       w_tick;
    logic       w_clear;

    // Restart the bit period so START gets a full CLKS_PER_BIT cycles
    assign w_clear = (r_state == TX_LATCH);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            readEn    <= 1'b0;
            txData    <= 1'b1;
            busy      <= 1'b0;
            txDone    <= 1'b0;
        end else begin
            readEn <= 1'b0;
            txDone <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    txData <= 1'b1;
                    if (!empty) begin
                        r_state <= TX_READ;
                        readEn  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                TX_READ: begin
                    r_state <= TX_LATCH;
                end
                TX_LATCH: begin
                    // Non-FWFT FIFO: data is valid the cycle after the strobe
                    r_shift   <= dout;
                    r_bit_idx <= '0;
                    txData    <= 1'b0;
                    r_state   <= TX_START;
                end
                TX_START: begin
                    if (w_tick) begin
                        txData  <= r_shift[0];
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            txData  <= 1'b1;
                            r_state <= TX_STOP;
                        end else begin
                            txData <= r_shift[1];
                        end
                    end
                end
                TX_STOP: begin
                    if (w_tick) begin
                        txDone  <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= TX_IDLE;
                    end
                end
                default: begin
                    txData  <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
//==============================================================================
// Module      : tb_uart_tx_serializer
// Description : Self-checking bench; FIFO model plus a reference UART receiver
//               per DUT instance (CLKS_PER_BIT = 4 and 2).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_serializer;

    typedef struct {
        logic [9:0] bits;     // line value per bit slot, [0] = start
        bit         uniform;  // every sample within each bit slot identical
        int         t_start;  // cycle of the falling start edge
    } frame_t;

    logic clk = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int N = (gi == 0) ? 4 : 2;

        logic       rst        = 1'b1;
        logic       empty      = 1'b1;
        logic       hold_empty = 1'b0;
        logic [7:0] dout       = 8'h00;
        logic       readEn;
        logic       txData;
        logic       busy;
        logic       txDone;
        logic [7:0] fifo_q[$];
        int         rd_cyc[$];
        int         done_cyc[$];
        frame_t     frames[$];

        uart_tx_serializer #(
            .CLKS_PER_BIT (N)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .empty  (empty),
            .dout   (dout),
            .readEn (readEn),
            .txData (txData),
            .busy   (busy),
            .txDone (txDone)
        );

        // Standard-read FIFO: a strobe pops the head onto dout for the next cycle
        initial forever begin
            @(negedge clk);
            if (readEn === 1'b1 && fifo_q.size() > 0) dout = fifo_q.pop_front();
            empty = (fifo_q.size() == 0) || hold_empty;
        end

        // Reference receiver: captures 10 bit slots of N samples after each fall
        initial begin : p_rx
            logic   samp [0:10*N-1];
            int     fpos;
            int     tstart;
            logic   prev;
            frame_t fr;
            fpos   = -1;
            tstart = 0;
            prev   = 1'b1;
            forever begin
                @(negedge clk);
                if (rst) begin
                    fpos = -1;
                    prev = 1'b1;
                end else begin
                    if (readEn === 1'b1) rd_cyc.push_back(cyc);
                    if (txDone === 1'b1) done_cyc.push_back(cyc);
                    if (fpos < 0) begin
                        if (prev === 1'b1 && txData === 1'b0) begin
                            tstart  = cyc;
                            samp[0] = txData;
                            fpos    = 1;
                        end
                    end else begin
                        samp[fpos] = txData;
                        fpos++;
                        if (fpos == 10*N) begin
                            fr.uniform = 1'b1;
                            for (int b = 0; b < 10; b++) begin
                                fr.bits[b] = samp[b*N + N/2];
                                for (int s = 0; s < N; s++)
                                    if (samp[b*N + s] !== fr.bits[b]) fr.uniform = 1'b0;
                            end
                            fr.t_start = tstart;
                            frames.push_back(fr);
                            fpos = -1;
                        end
                    end
                    prev = txData;
                end
            end
        end
    end

    task automatic wait_done(input int inst, input int n, input int budget, output int got);
        int k = 0;
        got = (inst == 0) ? g_inst[0].done_cyc.size() : g_inst[1].done_cyc.size();
        while (got < n && k < budget) begin
            @(negedge clk);
            k++;
            got = (inst == 0) ? g_inst[0].done_cyc.size() : g_inst[1].done_cyc.size();
        end
    endtask

    task automatic settle0();
        repeat (6) @(negedge clk);
        g_inst[0].frames.delete();
        g_inst[0].rd_cyc.delete();
        g_inst[0].done_cyc.delete();
    endtask

    task automatic test_reset();
        int     t_drop;
        int     got;
        frame_t f;
        g_inst[0].fifo_q.push_back(8'h11);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({g_inst[0].txData, g_inst[0].readEn, g_inst[0].busy, g_inst[0].txDone} !== 4'b1000) begin
                n_err++;
                $display("FAIL reset_hold: {txData,readEn,busy,txDone}=%b expected 1000",
                         {g_inst[0].txData, g_inst[0].readEn, g_inst[0].busy, g_inst[0].txDone});
            end
        end
        g_inst[0].rst = 1'b0;
        t_drop = cyc;
        wait_done(0, 1, 100, got);
        n_vec++;
        if (got != 1) begin
            n_err++;
            $display("FAIL reset_frame_done: got %0d txDone pulses expected 1", got);
        end
        n_vec++;
        if (g_inst[0].rd_cyc.size() != 1) begin
            n_err++;
            $display("FAIL reset_readen_count: got %0d expected 1", g_inst[0].rd_cyc.size());
        end else begin
            n_vec++;
            if (g_inst[0].rd_cyc[0] != t_drop + 1) begin
                n_err++;
                $display("FAIL reset_first_readen: cycle %0d expected %0d", g_inst[0].rd_cyc[0], t_drop + 1);
            end
        end
        if (g_inst[0].frames.size() > 0) begin
            f = g_inst[0].frames[0];
            n_vec++;
            if ({f.uniform, f.bits} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
                n_err++;
                $display("FAIL reset_frame_bits: got %b expected %b", {f.uniform, f.bits}, {1'b1, 1'b1, 8'h11, 1'b0});
            end
        end
        settle0();
    endtask

    task automatic test_single_byte();
        int     got;
        frame_t f;
        g_inst[0].fifo_q.push_back(8'hA5);
        wait_done(0, 1, 100, got);
        n_vec++;
        if (got != 1 || g_inst[0].frames.size() != 1) begin
            n_err++;
            $display("FAIL single_done: txDone=%0d frames=%0d expected 1/1", got, g_inst[0].frames.size());
        end else begin
            f = g_inst[0].frames[0];
            n_vec++;
            if ({f.uniform, f.bits} !== {1'b1, 10'b1_1010_0101_0}) begin
                n_err++;
                $display("FAIL single_bits: got %b expected %b", {f.uniform, f.bits}, {1'b1, 10'b1_1010_0101_0});
            end
            n_vec++;
            if (g_inst[0].done_cyc[0] != f.t_start + 40) begin
                n_err++;
                $display("FAIL single_txdone_time: cycle %0d expected %0d", g_inst[0].done_cyc[0], f.t_start + 40);
            end
            n_vec++;
            if (g_inst[0].rd_cyc.size() != 1 || g_inst[0].rd_cyc[0] + 2 != f.t_start) begin
                n_err++;
                $display("FAIL single_latency: readEn pulses %0d, start edge %0d expected readEn cycle + 2",
                         g_inst[0].rd_cyc.size(), f.t_start);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({g_inst[0].txData, g_inst[0].busy} !== 2'b10) begin
            n_err++;
            $display("FAIL single_idle_after: {txData,busy}=%b expected 10", {g_inst[0].txData, g_inst[0].busy});
        end
        settle0();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int         got;
        frame_t     f;
        frame_t     fp;
        exp_b[0] = 8'h00;
        exp_b[1] = 8'hFF;
        exp_b[2] = 8'h55;
        for (int i = 0; i < 3; i++) g_inst[0].fifo_q.push_back(exp_b[i]);
        wait_done(0, 3, 200, got);
        n_vec++;
        if (got != 3 || g_inst[0].frames.size() != 3 || g_inst[0].rd_cyc.size() != 3) begin
            n_err++;
            $display("FAIL b2b_counts: txDone=%0d frames=%0d readEn=%0d expected 3/3/3",
                     got, g_inst[0].frames.size(), g_inst[0].rd_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                f = g_inst[0].frames[i];
                n_vec++;
                if ({f.uniform, f.bits} !== {1'b1, 1'b1, exp_b[i], 1'b0}) begin
                    n_err++;
                    $display("FAIL b2b_bits[%0d]: got %b expected %b", i, {f.uniform, f.bits}, {1'b1, 1'b1, exp_b[i], 1'b0});
                end
                n_vec++;
                if (g_inst[0].done_cyc[i] != f.t_start + 40) begin
                    n_err++;
                    $display("FAIL b2b_txdone[%0d]: cycle %0d expected %0d", i, g_inst[0].done_cyc[i], f.t_start + 40);
                end
                if (i > 0) begin
                    fp = g_inst[0].frames[i-1];
                    n_vec++;
                    if (f.t_start - (fp.t_start + 40) != 3) begin
                        n_err++;
                        $display("FAIL b2b_gap[%0d]: got %0d idle cycles expected 3", i, f.t_start - (fp.t_start + 40));
                    end
                end
            end
        end
        settle0();
    endtask

    task automatic test_reset_mid_frame();
        int     k;
        int     got;
        int     t_rst;
        frame_t f;
        g_inst[0].fifo_q.push_back(8'h3C);
        k = 0;
        while (g_inst[0].rd_cyc.size() < 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (g_inst[0].rd_cyc.size() < 1) begin
            n_err++;
            $display("FAIL midrst_readen: got 0 pulses expected 1");
            return;
        end
        // middle of data bit 3: start edge + 4 bit periods + 1
        t_rst = g_inst[0].rd_cyc[0] + 2 + 4*4 + 1;
        while (cyc < t_rst && k < 60) begin
            @(negedge clk);
            k++;
        end
        g_inst[0].rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({g_inst[0].txData, g_inst[0].readEn, g_inst[0].busy, g_inst[0].txDone} !== 4'b1000) begin
            n_err++;
            $display("FAIL midrst_next_edge: {txData,readEn,busy,txDone}=%b expected 1000",
                     {g_inst[0].txData, g_inst[0].readEn, g_inst[0].busy, g_inst[0].txDone});
        end
        @(negedge clk);
        g_inst[0].rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++;
            if ({g_inst[0].txData, g_inst[0].readEn} !== 2'b10) begin
                n_err++;
                $display("FAIL midrst_quiet: cycle %0d {txData,readEn}=%b expected 10", c, {g_inst[0].txData, g_inst[0].readEn});
            end
        end
        n_vec++;
        if (g_inst[0].frames.size() != 0 || g_inst[0].done_cyc.size() != 0) begin
            n_err++;
            $display("FAIL midrst_discard: frames=%0d txDone=%0d expected 0/0",
                     g_inst[0].frames.size(), g_inst[0].done_cyc.size());
        end
        g_inst[0].fifo_q.push_back(8'h96);
        wait_done(0, 1, 100, got);
        n_vec++;
        if (got != 1 || g_inst[0].frames.size() != 1) begin
            n_err++;
            $display("FAIL midrst_next_byte: txDone=%0d frames=%0d expected 1/1", got, g_inst[0].frames.size());
        end else begin
            f = g_inst[0].frames[0];
            n_vec++;
            if ({f.uniform, f.bits} !== {1'b1, 1'b1, 8'h96, 1'b0}) begin
                n_err++;
                $display("FAIL midrst_bits: got %b expected %b", {f.uniform, f.bits}, {1'b1, 1'b1, 8'h96, 1'b0});
            end
        end
        settle0();
    endtask

    task automatic test_empty_toggle();
        logic [7:0] exp_b [2];
        int         k;
        int         got;
        int         rd_at_done;
        frame_t     f;
        exp_b[0] = 8'h5A;
        exp_b[1] = 8'hC3;
        g_inst[0].fifo_q.push_back(exp_b[0]);
        g_inst[0].fifo_q.push_back(exp_b[1]);
        k = 0;
        while (g_inst[0].rd_cyc.size() < 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (g_inst[0].txDone !== 1'b1 && k < 100) begin
            g_inst[0].hold_empty = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        rd_at_done = g_inst[0].rd_cyc.size();
        g_inst[0].hold_empty = 1'b0;
        n_vec++;
        if (rd_at_done != 1) begin
            n_err++;
            $display("FAIL toggle_no_read_midframe: got %0d readEn pulses expected 1", rd_at_done);
        end
        wait_done(0, 2, 150, got);
        n_vec++;
        if (got != 2 || g_inst[0].frames.size() != 2) begin
            n_err++;
            $display("FAIL toggle_done: txDone=%0d frames=%0d expected 2/2", got, g_inst[0].frames.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                f = g_inst[0].frames[i];
                n_vec++;
                if ({f.uniform, f.bits} !== {1'b1, 1'b1, exp_b[i], 1'b0}) begin
                    n_err++;
                    $display("FAIL toggle_bits[%0d]: got %b expected %b", i, {f.uniform, f.bits}, {1'b1, 1'b1, exp_b[i], 1'b0});
                end
                n_vec++;
                if (g_inst[0].done_cyc[i] != f.t_start + 40) begin
                    n_err++;
                    $display("FAIL toggle_timing[%0d]: txDone cycle %0d expected %0d", i, g_inst[0].done_cyc[i], f.t_start + 40);
                end
            end
        end
        settle0();
    endtask

    task automatic test_boundary();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         got;
        frame_t     f;
        frame_t     fp;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            g_inst[1].fifo_q.push_back(b);
        end
        @(negedge clk);
        g_inst[1].rst = 1'b0;
        wait_done(1, 64, 2000, got);
        n_vec++;
        if (got != 64 || g_inst[1].frames.size() != 64 || g_inst[1].rd_cyc.size() != 64) begin
            n_err++;
            $display("FAIL bound_counts: txDone=%0d frames=%0d readEn=%0d expected 64/64/64",
                     got, g_inst[1].frames.size(), g_inst[1].rd_cyc.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                f = g_inst[1].frames[i];
                n_vec++;
                if ({f.uniform, f.bits} !== {1'b1, 1'b1, exp_q[i], 1'b0}) begin
                    n_err++;
                    $display("FAIL bound_bits[%0d]: got %b expected %b", i, {f.uniform, f.bits}, {1'b1, 1'b1, exp_q[i], 1'b0});
                end
                if (i > 0) begin
                    fp = g_inst[1].frames[i-1];
                    n_vec++;
                    if (f.t_start - (fp.t_start + 20) != 3) begin
                        n_err++;
                        $display("FAIL bound_gap[%0d]: got %0d idle cycles expected 3", i, f.t_start - (fp.t_start + 20));
                    end
                end
            end
        end
    endtask

    initial begin
        g_inst[0].rst = 1'b1;
        g_inst[1].rst = 1'b1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_toggle();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
